// File: rtl/tmds_pkg.sv
// tmds_pkg: control-token constants and alignment state
// shared by the TMDS encoder and decoder
package tmds_pkg;

  localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] ctrl;
  } tok_t;

  function automatic tok_t tok_lookup(
    input logic [9:0] sym
  );
    tok_t t;
    t.hit  = 1'b1;
    t.ctrl = 2'b00;
    unique case (1'b1)
      (sym == CTRL_TOK_00): t.ctrl = 2'b00;
      (sym == CTRL_TOK_01): t.ctrl = 2'b01;
      (sym == CTRL_TOK_10): t.ctrl = 2'b10;
      (sym == CTRL_TOK_11): t.ctrl = 2'b11;
      default:              t.hit  = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: stage 1 of the receiver
// 10b->8b decode plus control-token detect, registered
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic       pclk,
  input  logic       rst_n,
  input  logic [9:0] sym,
  output logic       hit,
  output logic [1:0] ctrl,
  output logic [7:0] q
);

  logic [7:0] d;
  logic [7:0] q_c;
  tok_t       tok;

  // undo optional inversion, then the XOR/XNOR chain
  always_comb begin
    d      = sym[9] ? ~sym[7:0] : sym[7:0];
    q_c[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q_c[i] = sym[8] ? (d[i] ^ d[i-1])
                      : ~(d[i] ^ d[i-1]);
    end
    tok = tok_lookup(sym);
  end

  // stage-1 register of decoded byte and token flags
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hit  <= 1'b0;
      ctrl <= 2'b00;
      q    <= 8'h00;
    end else begin
      hit  <= tok.hit;
      ctrl <= tok.ctrl;
      q    <= q_c;
    end
  end

endmodule

// File: rtl/tmds_rx_decoder.sv
// tmds_rx_decoder: one TMDS channel receiver
// word alignment by token hunting, bitslip, decode
module tmds_rx_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_SETTLE    = 4,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic [9:0] data_i,
  output logic       bitslip_o,
  output logic       aligned_o,
  output logic [3:0] slip_cnt_o,
  output logic [7:0] data_o,
  output logic [1:0] ctrl_o,
  output logic       de_o
);

  localparam int RW = $clog2(LOCK_RUN + 1);
  localparam int TW = (SEARCH_TIMEOUT > 1) ?
                      $clog2(SEARCH_TIMEOUT) : 1;
  localparam int SW = (SLIP_SETTLE > 1) ?
                      $clog2(SLIP_SETTLE) : 1;
  localparam int LW = (LOSS_TIMEOUT > 1) ?
                      $clog2(LOSS_TIMEOUT) : 1;

  localparam logic [RW-1:0] RUN_LAST =
    RW'(LOCK_RUN - 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(SEARCH_TIMEOUT - 1);
  localparam logic [SW-1:0] SET_LAST =
    SW'(SLIP_SETTLE - 1);
  localparam logic [LW-1:0] LOSS_LAST =
    LW'(LOSS_TIMEOUT - 1);

  logic         s1_hit;
  logic [1:0]   s1_ctrl;
  logic [7:0]   s1_q;

  align_state_t state, state_nx;
  logic [RW-1:0] run_cnt, run_nx;
  logic [TW-1:0] tmo_cnt, tmo_nx;
  logic [SW-1:0] set_cnt, set_nx;
  logic [LW-1:0] loss_cnt, loss_nx;
  logic [3:0]    slip_nx;
  logic          pulse_nx;

  tmds_symbol_decode u_dec (
    .pclk  (pclk),
    .rst_n (rst_n),
    .sym   (data_i),
    .hit   (s1_hit),
    .ctrl  (s1_ctrl),
    .q     (s1_q)
  );

  assign aligned_o = (state == LOCKED);

  // alignment FSM registers
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      run_cnt    <= '0;
      tmo_cnt    <= '0;
      set_cnt    <= '0;
      loss_cnt   <= '0;
      slip_cnt_o <= 4'd0;
      bitslip_o  <= 1'b0;
    end else begin
      state      <= state_nx;
      run_cnt    <= run_nx;
      tmo_cnt    <= tmo_nx;
      set_cnt    <= set_nx;
      loss_cnt   <= loss_nx;
      slip_cnt_o <= slip_nx;
      bitslip_o  <= pulse_nx;
    end
  end

  // next state; a token always beats a timeout
  always_comb begin
    state_nx = state;
    run_nx   = run_cnt;
    tmo_nx   = tmo_cnt;
    set_nx   = set_cnt;
    loss_nx  = loss_cnt;
    slip_nx  = slip_cnt_o;
    pulse_nx = 1'b0;
    unique case (state)
      SEARCH: begin
        if (tmo_cnt != TMO_LAST) begin
          tmo_nx = tmo_cnt + 1'b1;
        end
        if (s1_hit) begin
          run_nx = run_cnt + 1'b1;
          if (run_cnt == RUN_LAST) begin
            state_nx = LOCKED;
            run_nx   = '0;
            tmo_nx   = '0;
            loss_nx  = '0;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_nx = SETTLE;
          pulse_nx = 1'b1;
          slip_nx  = (slip_cnt_o == 4'd9) ?
                     4'd0 : slip_cnt_o + 4'd1;
          run_nx   = '0;
          tmo_nx   = '0;
          set_nx   = '0;
        end else begin
          run_nx = '0;
        end
      end
      SETTLE: begin
        if (set_cnt == SET_LAST) begin
          state_nx = SEARCH;
          set_nx   = '0;
          run_nx   = '0;
          tmo_nx   = '0;
        end else begin
          set_nx = set_cnt + 1'b1;
        end
      end
      LOCKED: begin
        if (s1_hit) begin
          loss_nx = '0;
        end else if (loss_cnt == LOSS_LAST) begin
          state_nx = SEARCH;
          loss_nx  = '0;
          run_nx   = '0;
          tmo_nx   = '0;
        end else begin
          loss_nx = loss_cnt + 1'b1;
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

  // stage-2 output register, gated by lock
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      de_o   <= 1'b0;
      ctrl_o <= 2'b00;
      data_o <= 8'h00;
    end else if (state == LOCKED) begin
      if (s1_hit) begin
        de_o   <= 1'b0;
        ctrl_o <= s1_ctrl;
        data_o <= 8'h00;
      end else begin
        de_o   <= 1'b1;
        data_o <= s1_q;
      end
    end else begin
      de_o   <= 1'b0;
      ctrl_o <= 2'b00;
      data_o <= 8'h00;
    end
  end

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// tb_tmds_rx_decoder: random + directed bench
// against a behavioural receive model
module tb_tmds_rx_decoder;

  localparam int LR = 8;
  localparam int ST = 64;
  localparam int SS = 4;
  localparam int LT = 64;
  localparam logic [9:0] T0 = 10'b1101010100;
  localparam logic [9:0] T3 = 10'b1010101011;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] data_i = '0;
  logic       bitslip_o;
  logic       aligned_o;
  logic [3:0] slip_cnt_o;
  logic [7:0] data_o;
  logic [1:0] ctrl_o;
  logic       de_o;

  int total = 0;
  int bad = 0;
  int offs = 0;

  // behavioural model state
  bit         m_lock;
  int         m_run, m_age, m_settle;
  int         m_loss, m_slips;
  logic [9:0] m_s1;
  logic       e_de, e_slip;
  logic [1:0] e_ctrl;
  logic [7:0] e_data;

  always #5 pclk = ~pclk;

  tmds_rx_decoder #(
    .LOCK_RUN       (LR),
    .SEARCH_TIMEOUT (ST),
    .SLIP_SETTLE    (SS),
    .LOSS_TIMEOUT   (LT)
  ) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .data_i     (data_i),
    .bitslip_o  (bitslip_o),
    .aligned_o  (aligned_o),
    .slip_cnt_o (slip_cnt_o),
    .data_o     (data_o),
    .ctrl_o     (ctrl_o),
    .de_o       (de_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] tok_sym(input int c);
    case (c)
      0:       return 10'b1101010100;
      1:       return 10'b0010101011;
      2:       return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic int tok_idx(input logic [9:0] s);
    for (int c = 0; c < 4; c++)
      if (s == tok_sym(c)) return c;
    return -1;
  endfunction

  function automatic logic [9:0] rot(input logic [9:0] s,
                                     input int k);
    logic [19:0] x;
    x = {s, s};
    return x[k +: 10];
  endfunction

  task automatic model_reset();
    m_lock = 0; m_run = 0; m_age = 0;
    m_settle = 0; m_loss = 0; m_slips = 0;
    m_s1 = '0;
    e_de = 0; e_slip = 0; e_ctrl = 0; e_data = 0;
  endtask

  task automatic model_edge(input logic [9:0] sym);
    int ti;
    logic [7:0] d, q;
    ti = tok_idx(m_s1);
    d = m_s1[9] ? ~m_s1[7:0] : m_s1[7:0];
    q = d ^ {d[6:0], 1'b0};
    if (!m_s1[8]) q = q ^ 8'hFE;
    e_slip = 0;
    if (m_lock) begin
      if (ti >= 0) begin
        e_de = 0; e_ctrl = 2'(ti); e_data = 0;
      end else begin
        e_de = 1; e_data = q;
      end
    end else begin
      e_de = 0; e_ctrl = 0; e_data = 0;
    end
    if (m_lock) begin
      if (ti >= 0) m_loss = 0;
      else if (m_loss == LT - 1) begin
        m_lock = 0; m_loss = 0; m_run = 0; m_age = 0;
      end else m_loss++;
    end else if (m_settle > 0) begin
      m_settle--;
    end else begin
      if (ti >= 0) m_run++;
      else m_run = 0;
      if (m_run == LR) begin
        m_lock = 1; m_run = 0; m_age = 0; m_loss = 0;
      end else if (ti < 0 && m_age == ST - 1) begin
        e_slip = 1;
        m_slips = (m_slips + 1) % 10;
        m_settle = SS; m_run = 0; m_age = 0;
      end else if (m_age < ST - 1) begin
        m_age++;
      end
    end
    m_s1 = sym;
  endtask

  task automatic tick(input logic [9:0] sym);
    data_i = sym;
    @(posedge pclk);
    model_edge(sym);
    @(negedge pclk);
    chk("aligned", aligned_o, m_lock);
    chk("bitslip", bitslip_o, e_slip);
    chk("slip_cnt", slip_cnt_o, m_slips);
    chk("de", de_o, e_de);
    chk("ctrl", ctrl_o, e_ctrl);
    chk("data", data_o, e_data);
    if (bitslip_o === 1'b1) offs = (offs + 1) % 10;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_al"}, aligned_o, 0);
    chk({tag, "_bs"}, bitslip_o, 0);
    chk({tag, "_sc"}, slip_cnt_o, 0);
    chk({tag, "_de"}, de_o, 0);
    chk({tag, "_ct"}, ctrl_o, 0);
    chk({tag, "_da"}, data_o, 0);
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst_n = 1'b0;
    data_i = '0;
    model_reset();
    @(posedge pclk);
    @(negedge pclk);
    chk_zero("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    int n, len, pulses, last, sel;
    model_reset();
    do_reset();

    // lock and decode
    for (int i = 0; i < 8; i++) tick(T0);
    tick(10'b0100000000);
    chk("lock_al", aligned_o, 1);
    chk("lock_de", de_o, 0);
    chk("lock_ct", ctrl_o, 0);
    tick(10'b1100000000);
    chk("d0_de", de_o, 1);
    chk("d0_da", data_o, 8'h00);
    tick(T0);
    chk("d1_da", data_o, 8'h01);

    // control recovery
    tick(T3);
    tick(10'b0100000000);
    chk("c3_ct", ctrl_o, 2'b11);
    chk("c3_de", de_o, 0);
    tick(T0);
    chk("c3h_de", de_o, 1);
    chk("c3h_ct", ctrl_o, 2'b11);

    // loss: token at 63 saves, 64 gaps lose
    for (int i = 0; i < 63; i++) tick(10'h100);
    tick(T0);
    for (int i = 0; i < 63; i++) tick(10'h100);
    tick(10'h100);
    chk("loss_hold", aligned_o, 1);
    tick(10'h100);
    chk("loss_drop", aligned_o, 0);

    // broken run
    do_reset();
    for (int i = 0; i < 7; i++) tick(T0);
    tick(10'h100);
    for (int i = 0; i < 7; i++) tick(T0);
    tick(10'h100);
    tick(10'h100);
    chk("brk_nolock", aligned_o, 0);
    for (int i = 0; i < 8; i++) tick(T0);
    chk("brk_pre", aligned_o, 0);
    tick(T0);
    chk("brk_lock", aligned_o, 1);

    // misaligned deserializer needing 3 slips
    do_reset();
    offs = 7;
    pulses = 0; last = -1; n = 0;
    while (aligned_o !== 1'b1 && n < 400) begin
      tick(rot(T0, offs));
      n++;
      if (bitslip_o === 1'b1) begin
        pulses++;
        if (last >= 0) chk("slip_gap", n - last, ST + SS);
        last = n;
      end
    end
    chk("mis_pulses", pulses, 3);
    chk("mis_cnt", slip_cnt_o, 3);
    chk("mis_lock", aligned_o, 1);

    // async reset mid-stream
    @(posedge pclk);
    #2 rst_n = 1'b0;
    #1 chk_zero("arst");
    model_reset();
    @(negedge pclk);
    rst_n = 1'b1;

    // random traffic
    n = 0;
    while (n < 3000) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: begin
          len = $urandom_range(1, 12);
          for (int i = 0; i < len; i++)
            tick(tok_sym($urandom_range(0, 3)));
        end
        1: begin
          len = $urandom_range(1, 8);
          for (int i = 0; i < len; i++)
            tick(10'($urandom_range(0, 1023)));
        end
        2: begin
          len = $urandom_range(60, 70);
          for (int i = 0; i < len; i++)
            tick(10'($urandom_range(0, 1023)));
        end
        default: begin
          len = $urandom_range(8, 10);
          for (int i = 0; i < len; i++)
            tick(tok_sym($urandom_range(0, 3)));
        end
      endcase
      n += len;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
